// File: rtl/apb_master_bridge_pkg.sv
// Shared APB requester types and widths.
// Also imported by the apb_slave benches.
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_mst_state_e;

    // Wait-counter width; a disabled timeout still needs a 1-bit counter.
    function automatic int timer_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response handshake plus the APB3 requester-side bus.
// The bridge takes the master modport; the controller/completer side takes slave.
interface apb_master_bridge_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
               PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
               PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

endinterface

// File: rtl/apb_master_bridge_wait_timer.sv
// Counts ACCESS cycles without PREADY and flags the cycle on which the
// transfer must be abandoned. TIMEOUT of 0 never expires.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_srst,
    input  logic i_clear,
    input  logic i_enable,
    input  logic i_pready,
    output logic o_expire
);
    localparam int            CW    = timer_width(TIMEOUT);
    localparam logic [CW-1:0] LIMIT = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] MAX   = '1;

    logic [CW-1:0] r_count;

    // Saturates so a long stall can never wrap back below the limit.
    always_ff @(posedge i_clk) begin
        if (i_srst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !i_pready && (r_count != MAX)) begin
            r_count <= r_count + CW'(1);
        end
    end

    // PREADY in the same cycle suppresses expiry, so a late completion wins.
    assign o_expire = (TIMEOUT != 0) && i_enable && !i_pready && (r_count == LIMIT);

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 requester: one command in, one APB transfer, one response beat out.
// All outputs come straight from registers.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                PCLK,
    input  logic                PRESET,
    apb_master_bridge_if.master bus
);
    apb_mst_state_e    r_state;
    logic              r_cmd_ready;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_rsp_timeout;
    logic              w_expire;

    apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .i_clk    (PCLK),
        .i_srst   (PRESET),
        .i_clear  (r_state == SETUP),
        .i_enable (r_state == ACCESS),
        .i_pready (bus.PREADY),
        .o_expire (w_expire)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state       <= IDLE;
            r_cmd_ready   <= 1'b0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_psel      <= 1'b1;
                        r_pwrite    <= bus.cmd_write;
                        r_paddr     <= bus.cmd_addr;
                        r_pwdata    <= bus.cmd_wdata;
                        r_state     <= SETUP;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    if (bus.PREADY) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= r_pwrite ? '0 : bus.PRDATA;
                        r_rsp_err     <= bus.PSLVERR;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= RESP;
                    end else if (w_expire) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= RESP;
                    end
                end
                RESP: begin
                    // Ready is raised here so IDLE can accept on its first cycle.
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready   = r_cmd_ready;
    assign bus.PSEL        = r_psel;
    assign bus.PENABLE     = r_penable;
    assign bus.PWRITE      = r_pwrite;
    assign bus.PADDR       = r_paddr;
    assign bus.PWDATA      = r_pwdata;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: a driver issues commands and
// pushes model expectations, a completer model answers, a monitor checks.
module tb_apb_master_bridge;
    import apb_pkg::*;

    localparam int AW = APB_ADDR_W;
    localparam int DW = APB_DATA_W;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb_master_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .PCLK   (clk),
        .PRESET (rst),
        .bus    (bus)
    );

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            wait_n;
        logic          err_in;
        int            hold;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        logic          exp_to;
        int            exp_lat;
        int            exp_pen;
    } txn_t;

    txn_t          sb[$];
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] comp_mem[256];
    int            n_vec = 0;
    int            n_fail = 0;
    int            last_pop_cyc = 0;

    // Address 5 initialises to 0x5C.
    function automatic logic [DW-1:0] mem_init(input int i);
        return 8'(i * 37 + 163);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return {1'b0, bus.cmd_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err,
                bus.rsp_timeout, bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA};
    endfunction

    // Reference model: outcome of a transfer from the completer's wait count.
    task automatic push_txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int wn, input logic e, input int hold);
        txn_t t;
        t.write     = w;
        t.addr      = a;
        t.wdata     = d;
        t.wait_n    = wn;
        t.err_in    = e;
        t.hold      = hold;
        t.exp_to    = (wn >= TO);
        t.exp_pen   = t.exp_to ? TO : wn + 1;
        t.exp_lat   = 3 + (t.exp_to ? TO - 1 : wn);
        t.exp_err   = t.exp_to | e;
        t.exp_rdata = (w || t.exp_to) ? '0 : ref_mem[a];
        if (w && !t.exp_to && !e) ref_mem[a] = d;
        sb.push_back(t);
    endtask

    task automatic issue(input bit push, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int wn, input logic e,
                         input int hold, output int acc);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        if (push) push_txn(w, a, d, wn, e, hold);
        acc = -1;
        for (int i = 0; i < 200 && acc < 0; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) acc = cyc;
        end
        if (acc < 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL accept_timeout: got cmd_ready=0 for 200 cycles, required 1");
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'($urandom);
        bus.cmd_addr  = 8'($urandom);
        bus.cmd_wdata = 8'($urandom);
    endtask

    task automatic wait_all();
        int n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    // Completer: PREADY after wait_n not-ready ACCESS cycles; noise otherwise.
    initial begin
        int acc = 0;
        for (int i = 0; i < 256; i++) comp_mem[i] = mem_init(i);
        bus.PREADY  = 1'b0;
        bus.PRDATA  = '0;
        bus.PSLVERR = 1'b0;
        forever begin
            @(negedge clk);
            bus.PREADY  = 1'b0;
            bus.PRDATA  = 8'($urandom);
            bus.PSLVERR = 1'($urandom);
            if (bus.PSEL && !bus.PENABLE) begin
                acc = 0;
            end else if (bus.PSEL && bus.PENABLE) begin
                if (sb.size() > 0 && acc == sb[0].wait_n) begin
                    bus.PREADY  = 1'b1;
                    bus.PSLVERR = sb[0].err_in;
                    if (bus.PWRITE) begin
                        if (!sb[0].err_in) comp_mem[bus.PADDR] = bus.PWDATA;
                    end else begin
                        bus.PRDATA = comp_mem[bus.PADDR];
                    end
                end
                acc++;
            end
        end
    end

    // Monitor: protocol bookkeeping and response comparison.
    initial begin
        int            psel_n = 0, pen_n = 0, hold_n = 0, lat = 0, acc_cyc = 0, n_txn = 0;
        bit            first = 1'b1, stab_bad = 1'b0, busy_bad = 1'b0, held_bad = 1'b0;
        logic [DW-1:0] h_rdata;
        logic          h_err, h_to;
        txn_t          t;
        h_rdata = '0;
        h_err = 1'b0;
        h_to = 1'b0;
        bus.rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                psel_n = 0; pen_n = 0; hold_n = 0; first = 1'b1;
                stab_bad = 1'b0; busy_bad = 1'b0; held_bad = 1'b0;
                bus.rsp_ready = 1'b0;
            end else begin
                if (bus.cmd_valid && bus.cmd_ready) acc_cyc = cyc;
                if (bus.cmd_ready && (bus.PSEL || bus.rsp_valid)) busy_bad = 1'b1;
                if (bus.PSEL && !bus.PENABLE) begin
                    psel_n = 1; pen_n = 0; stab_bad = 1'b0;
                end else if (bus.PSEL) begin
                    psel_n++; pen_n++;
                end
                if (bus.PSEL && sb.size() > 0) begin
                    if (bus.PADDR !== sb[0].addr || bus.PWDATA !== sb[0].wdata ||
                        bus.PWRITE !== sb[0].write) stab_bad = 1'b1;
                end
                if (!bus.rsp_valid) begin
                    bus.rsp_ready = 1'b0;
                end else if (sb.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 with nothing outstanding, required 0");
                    bus.rsp_ready = 1'b1;
                end else begin
                    t = sb[0];
                    if (first) begin
                        lat = cyc - acc_cyc;
                        h_rdata = bus.rsp_rdata; h_err = bus.rsp_err; h_to = bus.rsp_timeout;
                        first = 1'b0;
                        held_bad = 1'b0;
                    end else if (bus.rsp_rdata !== h_rdata || bus.rsp_err !== h_err ||
                                 bus.rsp_timeout !== h_to) begin
                        held_bad = 1'b1;
                    end
                    if (bus.PSEL) busy_bad = 1'b1;
                    if (hold_n < t.hold) begin
                        hold_n++;
                        bus.rsp_ready = 1'b0;
                    end else begin
                        n_txn++;
                        $display("txn %0d: %s addr=0x%02h wait=%0d rdata=0x%02h err=%0b to=%0b lat=%0d",
                                 n_txn, t.write ? "WR" : "RD", t.addr, t.wait_n,
                                 bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout, lat);
                        check("rsp_rdata", 32'(bus.rsp_rdata), 32'(t.exp_rdata));
                        check("rsp_err", 32'(bus.rsp_err), 32'(t.exp_err));
                        check("rsp_timeout", 32'(bus.rsp_timeout), 32'(t.exp_to));
                        check("latency", 32'(lat), 32'(t.exp_lat));
                        check("psel_cycles", 32'(psel_n), 32'(t.exp_pen + 1));
                        check("penable_cycles", 32'(pen_n), 32'(t.exp_pen));
                        check("addr_data_stable", 32'(stab_bad), 32'd0);
                        check("ready_while_busy", 32'(busy_bad), 32'd0);
                        check("rsp_held", 32'(held_bad), 32'd0);
                        void'(sb.pop_front());
                        last_pop_cyc = cyc;
                        hold_n = 0;
                        first = 1'b1;
                        busy_bad = 1'b0;
                        bus.rsp_ready = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by 1ms, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_a, acc_b, pen, budget;
        bit saw;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem_init(i);

        repeat (3) @(posedge clk); #1;
        check("reset_outputs", out_vec(), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", 32'(bus.cmd_ready), 32'd1);

        issue(1, 1'b1, 8'h03, 8'hA5, 4, 1'b0, 0, acc_a);
        wait_all();
        issue(1, 1'b0, 8'h05, 8'h00, 0, 1'b0, 0, acc_a);
        wait_all();
        issue(1, 1'b1, 8'h10, 8'h3C, 2, 1'b1, 0, acc_a);
        wait_all();
        issue(1, 1'b0, 8'h40, 8'h00, 40, 1'b0, 0, acc_a);
        wait_all();
        issue(1, 1'b0, 8'h41, 8'h00, TO - 1, 1'b0, 0, acc_a);
        wait_all();

        // Second command offered while the first waits in RESP.
        issue(1, 1'b1, 8'h20, 8'hD7, 1, 1'b0, 5, acc_a);
        issue(1, 1'b0, 8'h20, 8'h11, 0, 1'b0, 0, acc_b);
        check("accept_after_idle", 32'(acc_b), 32'(last_pop_cyc + 1));
        wait_all();

        // Reset in the second ACCESS cycle of an unanswered transfer.
        issue(0, 1'b0, 8'h22, 8'h77, 0, 1'b0, 0, acc_a);
        pen = 0;
        budget = 0;
        while (pen < 2 && budget < 50) begin
            @(negedge clk);
            budget++;
            if (bus.PENABLE) pen++;
        end
        check("reset_reach_access", 32'(pen), 32'd2);
        rst = 1'b1;
        @(posedge clk); #1;
        check("reset_mid_outputs", out_vec(), 32'd0);
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        saw = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.rsp_valid) saw = 1'b1;
        end
        check("no_rsp_after_reset", 32'(saw), 32'd0);
        issue(1, 1'b0, 8'h03, 8'h00, 2, 1'b0, 0, acc_a);
        wait_all();

        for (int n = 0; n < 150; n++) begin
            int wn;
            wn = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO - 2, TO + 2))
                                             : int'($urandom_range(0, 5));
            issue(1, 1'($urandom), 8'($urandom_range(0, 31)), 8'($urandom), wn,
                  ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)), acc_a);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        wait_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

APB requester that turns single command/response handshakes from an internal controller into APB3 transfers on PSEL/PENABLE/PADDR/PWRITE/PWDATA. It completes each transfer on PREADY and returns PRDATA/PSLVERR as one response beat. It drives the existing `apb_slave` (8-bit address/data, N wait states) and any compatible completer. A bounded PREADY timeout protects the controller from a hung completer.

## Interface
- ADDR_W, 8, PADDR / cmd_addr width
- DATA_W, 8, PWDATA / PRDATA / cmd_wdata / rsp_rdata width
- TIMEOUT, 16, maximum ACCESS cycles without PREADY before abort; 0 disables the timeout
- PCLK  in  1  clock; all logic is on the rising edge
- PRESET  in  1  reset: one clock, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  bridge can accept a command; high only in IDLE
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data; ignored for reads
- rsp_valid  out  1  response available
- rsp_ready  in  1  controller accepts the response
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts
- rsp_err  out  1  PSLVERR was seen, or a timeout occurred
- rsp_timeout  out  1  transfer was aborted by the timeout
- PSEL, PENABLE, PWRITE  out  1  APB controls
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  completer ready
- PSLVERR  in  1  completer error

## Operation
- FSM states are IDLE, SETUP, ACCESS and RESP. Every output is a register.
- **IDLE**
  - cmd_ready=1, PSEL=0, PENABLE=0.
  - On cmd_valid && cmd_ready: latch cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA, then go to SETUP.
- **SETUP**
  - PSEL=1, PENABLE=0.
  - Always advances to ACCESS; clear the timeout counter.
- **ACCESS**
  - PSEL=1, PENABLE=1.
  - On PREADY=1:
    - capture rsp_rdata = PWRITE ? 0 : PRDATA
    - rsp_err = PSLVERR, rsp_timeout = 0
    - drop PSEL and PENABLE, go to RESP.
  - Otherwise increment the counter.
  - When the counter reaches TIMEOUT-1 and PREADY=0 (TIMEOUT≠0):
    - drop PSEL and PENABLE
    - rsp_rdata = 0, rsp_err = 1, rsp_timeout = 1
    - go to RESP.
- **RESP**
  - rsp_valid=1; rsp_rdata, rsp_err and rsp_timeout are held.
  - On rsp_ready: clear rsp_valid, go to IDLE.
- PADDR, PWRITE and PWDATA are stable from SETUP through the last ACCESS cycle. In IDLE/RESP they hold their last value.
- cmd_valid outside IDLE is ignored; there is no queueing.
- Timeout counter width is $clog2(TIMEOUT+1). It saturates and does not wrap.

## Timing
- **Reset:** PRESET sampled high →
  - state = IDLE at the next edge
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA = 0
  - rsp_valid, rsp_rdata, rsp_err, rsp_timeout = 0
  - cmd_ready = 0 while PRESET is high, 1 after release.
- **Reset mid-transfer** (SETUP, ACCESS or RESP): the transfer is abandoned and no response is produced.
- **Phases**, with the command accepted at edge k:
  - SETUP phase is cycle k+1.
  - PENABLE is high from cycle k+2.
- **Zero-wait completer:** rsp_valid is high in cycle k+3.
- **W-wait completer:** PENABLE is high for W+1 cycles; rsp_valid is high in cycle k+3+W.
- **PREADY on the timeout cycle:** PREADY=1 wins, so the transfer completes normally with rsp_timeout=0.
- **Timeout:** PENABLE is high for exactly TIMEOUT cycles.
- **Throughput:** with rsp_ready held high, RESP lasts 1 cycle and the minimum is 4 cycles per transfer (zero-wait).
- **Back-to-back:** a new SETUP never directly follows ACCESS; PSEL goes low for at least 2 cycles (RESP, IDLE).

## Structure
- Package apb_pkg holds:
  - state enum apb_mst_state_e {IDLE, SETUP, ACCESS, RESP}
  - APB_ADDR_W = 8 and APB_DATA_W = 8 constants, shared with apb_slave benches.
- One sub-module, apb_wait_timer:
  - inputs: clear, enable, PREADY
  - output: one-cycle expire pulse, parameterised by TIMEOUT.
- Top module holds the FSM and the datapath registers.

## Test plan
1. **Write with wait states:** write cmd addr 0x03, wdata 0xA5; completer with 4 wait states →
   - PSEL high 6 cycles, PENABLE high 5 cycles
   - PADDR = 0x03 and PWDATA = 0xA5 stable throughout
   - rsp_valid with rsp_err = 0, rsp_rdata = 0.
2. **Zero-wait read:** read addr 0x05; completer PREADY=1 immediately, PRDATA = 0x5C → rsp_valid at k+3, rsp_rdata = 0x5C, rsp_err = 0.
3. **Completer error:** write addr 0x10; completer PSLVERR=1 with PREADY → rsp_err = 1, rsp_timeout = 0.
4. **Timeout:** TIMEOUT = 16, PREADY stuck 0 →
   - PENABLE high exactly 16 cycles, then PSEL = 0
   - rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
   - Repeat with PREADY=1 on the 16th ACCESS cycle → normal completion.
5. **Response backpressure:** rsp_ready = 0 for 5 cycles → rsp_valid and its data held, cmd_ready = 0, PSEL = 0, a cmd_valid offered meanwhile is not accepted; accepted the cycle after IDLE returns.
6. **Reset mid-ACCESS:** PRESET = 1 during the 2nd ACCESS cycle → next edge all outputs 0; no rsp_valid after release; next command runs normally.
